ysyx_22040750_trap_ctrl: RTL and testbench
==========================================

# ysyx_22040750_trap_ctrl

Trap sequencer for the machine-mode CSR file. It owns the CLINT timer (mtime/mtimecmp), decides when a trap or mret is taken, drains the pipeline for asynchronous interrupts, and drives the CSR file's trap-entry, trap-read, mret-write and mret-read strobes. It sits beside the CSR file at the WB stage and redirects fetch to the trap vector (mtvec) or the return address (mepc).

## Interface
Parameters:
- TICK_DIV, 1: mtime increments once every TICK_DIV clocks; legal range 1..65535.
- CLINT_BASE, 32'h0200_0000: CLINT MMIO base; mtimecmp at +0x4000, mtime at +0xBFF8.

Ports:
- I_sys_clk  in  1  single clock, all state on rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_wb_valid  in  1  WB holds a retiring instruction.
- I_wb_ecall  in  1  retiring instruction is ecall.
- I_wb_mret  in  1  retiring instruction is mret.
- I_wb_pc  in  32  PC of the retiring instruction.
- I_next_pc  in  32  PC of the oldest unretired/next-fetch instruction, valid when drained.
- I_pipe_empty  in  1  no valid instruction in IF..WB.
- I_mstatus_mie  in  1  mstatus.MIE from the CSR file.
- I_csr_rd_data  in  64  CSR file read port; carries mtvec or mepc while the strobes are asserted.
- O_csr_intr_wr / O_csr_intr_rd  out  1  trap-entry strobes to the CSR file.
- O_csr_mret_wr / O_csr_mret_rd  out  1  mret strobes to the CSR file.
- O_intr_pc  out  32  value written to mepc.
- O_intr_no  out  64  value written to mcause.
- O_stall_if  out  1  blocks new fetch while draining.
- O_redirect  out  1  one-cycle fetch redirect pulse.
- O_redirect_pc  out  32  redirect target, I_csr_rd_data[31:0].
- I_mmio_wen / I_mmio_ren  in  1  CLINT access strobes.
- I_mmio_addr  in  32  byte address.
- I_mmio_wdata  in  64  write data.
- I_mmio_wmask  in  8  byte enables.
- O_mmio_rdata  out  64  read data, combinational; 0 when the address misses.
- I_timer_irq  in  1  external timer interrupt. Present only without the CLINT macro.

## Operation
- FSM states: IDLE, DRAIN, TRAP, MRET.
- From IDLE:
  - I_wb_valid & I_wb_mret → MRET.
  - Otherwise I_wb_valid & I_wb_ecall → TRAP, with cause 64'd11 and epc I_wb_pc.
  - Otherwise irq_pend & I_mstatus_mie → DRAIN.
  - irq_pend = (mtime >= mtimecmp), unsigned 64-bit compare. Without the CLINT macro, irq_pend = I_timer_irq.
- DRAIN:
  - O_stall_if = 1.
  - When I_pipe_empty → TRAP, with cause 64'h8000_0000_0000_0007 and epc I_next_pc.
  - If irq_pend drops or I_mstatus_mie clears before then → IDLE, with stall released and no trap.
- TRAP, one cycle:
  - O_csr_intr_wr = O_csr_intr_rd = 1.
  - O_intr_pc = latched epc; O_intr_no = latched cause.
  - O_redirect = 1, O_redirect_pc = I_csr_rd_data[31:0] (mtvec).
  - → IDLE.
- MRET, one cycle:
  - O_csr_mret_wr = O_csr_mret_rd = 1.
  - O_redirect = 1, O_redirect_pc = I_csr_rd_data[31:0] (mepc).
  - → IDLE.
- Only one WB event is accepted per cycle. mret has priority over ecall, and ecall over an interrupt. A pending interrupt is re-evaluated in IDLE after TRAP, where MIE is already cleared.
- All strobes are 0 outside TRAP/MRET. O_stall_if is 1 in DRAIN, TRAP and MRET.
- CLINT:
  - A prescaler counts 0..TICK_DIV-1; mtime += 1 on wrap. mtime wraps 2^64-1 → 0.
  - MMIO writes are byte-masked.
  - An mtime write in the same cycle as a tick: the write wins and the tick is dropped.
  - A mtimecmp write takes effect on the compare in the next cycle.

## Timing
- Reset values: state IDLE; all outputs 0; mtime 0; mtimecmp 64'hFFFF_FFFF_FFFF_FFFF; prescaler 0.
- ecall/mret at WB in cycle N: strobes and redirect in cycle N+1.
- Interrupt latency: detection in cycle N, DRAIN from N+1, TRAP one cycle after I_pipe_empty is first sampled high.
- Reset asserted mid-DRAIN/TRAP: the FSM returns to IDLE immediately and asynchronously. The CSR file sees no partial strobe after reset deassertion.
- The MMIO read is combinational. A write is visible to reads in the next cycle.

## Configuration
- YSYX_22040750_CLINT_EN defined: internal mtime/mtimecmp, the MMIO port and the prescaler are built; I_timer_irq is absent.
- Undefined: no CLINT registers; O_mmio_rdata ties to 0; irq_pend = I_timer_irq (level, assumed synchronous to I_sys_clk).

## Structure
- Shared package ysyx_22040750_csr_pkg holds:
  - FSM state encoding.
  - Cause constants CAUSE_ECALL_M and CAUSE_MTIMER.
  - CSR address constants (MEPC, MSTATUS, MTVEC, MCAUSE, MSCRATCH).
  - CLINT offsets.
- Sub-module ysyx_22040750_clint contains mtime, mtimecmp, the prescaler and the MMIO decode. It is instantiated only under the macro.

## Test plan
- Reset → all outputs 0; MMIO read of CLINT_BASE+0x4000 returns 64'hFFFF_FFFF_FFFF_FFFF.
- ecall retiring at pc 0x8000_0010, mtvec 0x8000_0100 → next cycle intr_wr=1, intr_no=11, intr_pc=0x8000_0010, redirect_pc=0x8000_0100.
- mret retiring, mepc 0x8000_0014 → next cycle mret_wr=mret_rd=1, redirect_pc=0x8000_0014, intr_wr=0.
- TICK_DIV=1, mtimecmp=10, MIE=1, pipe_empty asserted 3 cycles after mtime reaches 10 → DRAIN for 3 cycles, then TRAP with intr_no=64'h8000_0000_0000_0007 and intr_pc=I_next_pc.
- MIE=0 with the timer pending → no trap. ecall and pending interrupt in the same cycle → ecall trap first, no timer trap while MIE=0.
- mtime=64'hFFFF_FFFF_FFFF_FFFF → wraps to 0 after TICK_DIV cycles. Reset pulse during DRAIN → IDLE, no strobe.

Source files
------------

// File: rtl/ysyx_22040750_csr_pkg.sv
// ysyx_22040750_csr_pkg: constants and types shared by the trap sequencer and the CLINT.
package ysyx_22040750_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2,
        ST_MRET  = 2'd3
    } trap_state_e;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTIMER  = 64'h8000_0000_0000_0007;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam logic [31:0] CLINT_MTIMECMP_OFS = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIME_OFS    = 32'h0000_BFF8;

    // Merge write data into an old register value, one byte lane per mask bit.
    function automatic logic [63:0] apply_wmask(input logic [63:0] old_val,
                                                input logic [63:0] wdata,
                                                input logic [7:0]  wmask);
        logic [63:0] merged;
        merged = old_val;
        for (int b = 0; b < 8; b++) begin
            if (wmask[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ysyx_22040750_clint.sv
// ysyx_22040750_clint: mtime/mtimecmp timer with prescaler and MMIO decode.
// Only instantiated when YSYX_22040750_CLINT_EN is defined.
module ysyx_22040750_clint
    import ysyx_22040750_csr_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wen,
    input  logic        i_ren,
    input  logic [31:0] i_addr,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_wmask,
    output logic [63:0] o_rdata,
    output logic        o_irq_pend
);

    localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

    logic [15:0] r_prescale;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        w_tick;
    logic        w_hit_mtime;
    logic        w_hit_cmp;

    assign w_tick      = (r_prescale == PRE_MAX);
    assign w_hit_mtime = (i_addr == CLINT_BASE + CLINT_MTIME_OFS);
    assign w_hit_cmp   = (i_addr == CLINT_BASE + CLINT_MTIMECMP_OFS);
    assign o_irq_pend  = (r_mtime >= r_mtimecmp);

    // Prescaler counts 0..TICK_DIV-1 and produces one tick on wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_prescale <= '0;
        else if (w_tick) r_prescale <= '0;
        else             r_prescale <= r_prescale + 16'd1;
    end

    // mtime: a software write beats a simultaneous tick, which is then lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                   r_mtime <= '0;
        else if (i_wen && w_hit_mtime)  r_mtime <= apply_wmask(r_mtime, i_wdata, i_wmask);
        else if (w_tick)                r_mtime <= r_mtime + 64'd1;
    end

    // mtimecmp resets to all ones so no interrupt is pending out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_mtimecmp <= '1;
        else if (i_wen && w_hit_cmp) r_mtimecmp <= apply_wmask(r_mtimecmp, i_wdata, i_wmask);
    end

    // Combinational read port; misses and idle cycles read as zero.
    always_comb begin
        o_rdata = '0;
        if (i_ren && w_hit_cmp)        o_rdata = r_mtimecmp;
        else if (i_ren && w_hit_mtime) o_rdata = r_mtime;
    end

endmodule

// File: rtl/ysyx_22040750_trap_ctrl.sv
// ysyx_22040750_trap_ctrl: trap/mret sequencer beside the machine-mode CSR file.
// YSYX_22040750_CLINT_EN builds the internal CLINT; otherwise I_timer_irq is the interrupt source.
module ysyx_22040750_trap_ctrl
    import ysyx_22040750_csr_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic        I_wb_valid,
    input  logic        I_wb_ecall,
    input  logic        I_wb_mret,
    input  logic [31:0] I_wb_pc,
    input  logic [31:0] I_next_pc,
    input  logic        I_pipe_empty,
    input  logic        I_mstatus_mie,
    input  logic [63:0] I_csr_rd_data,
    output logic        O_csr_intr_wr,
    output logic        O_csr_intr_rd,
    output logic        O_csr_mret_wr,
    output logic        O_csr_mret_rd,
    output logic [31:0] O_intr_pc,
    output logic [63:0] O_intr_no,
    output logic        O_stall_if,
    output logic        O_redirect,
    output logic [31:0] O_redirect_pc,
    input  logic        I_mmio_wen,
    input  logic        I_mmio_ren,
    input  logic [31:0] I_mmio_addr,
    input  logic [63:0] I_mmio_wdata,
    input  logic [7:0]  I_mmio_wmask,
`ifndef YSYX_22040750_CLINT_EN
    input  logic        I_timer_irq,
`endif
    output logic [63:0] O_mmio_rdata
);

    trap_state_e r_state;
    trap_state_e w_next_state;
    logic [31:0] r_epc;
    logic [63:0] r_cause;
    logic        w_irq_pend;
    logic        w_irq_take;
    logic        w_load_ecall;
    logic        w_load_timer;
    logic        w_unused;

`ifdef YSYX_22040750_CLINT_EN
    ysyx_22040750_clint #(
        .TICK_DIV   (TICK_DIV),
        .CLINT_BASE (CLINT_BASE)
    ) u_clint (
        .i_clk      (I_sys_clk),
        .i_rst_n    (I_rst_n),
        .i_wen      (I_mmio_wen),
        .i_ren      (I_mmio_ren),
        .i_addr     (I_mmio_addr),
        .i_wdata    (I_mmio_wdata),
        .i_wmask    (I_mmio_wmask),
        .o_rdata    (O_mmio_rdata),
        .o_irq_pend (w_irq_pend)
    );
    assign w_unused = ^I_csr_rd_data[63:32];
`else
    assign w_irq_pend   = I_timer_irq;
    assign O_mmio_rdata = '0;
    assign w_unused     = ^{I_csr_rd_data[63:32], I_mmio_wen, I_mmio_ren, I_mmio_addr,
                            I_mmio_wdata, I_mmio_wmask, CLINT_BASE, 32'(TICK_DIV)};
`endif

    assign w_irq_take = w_irq_pend & I_mstatus_mie;

    // State register; reset drops straight back to IDLE so no strobe survives it.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Capture the return address and cause at the moment a trap is committed.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_epc   <= '0;
            r_cause <= '0;
        end else if (w_load_ecall) begin
            r_epc   <= I_wb_pc;
            r_cause <= CAUSE_ECALL_M;
        end else if (w_load_timer) begin
            r_epc   <= I_next_pc;
            r_cause <= CAUSE_MTIMER;
        end
    end

    // Next-state and strobe decode; mret beats ecall beats interrupt, and an
    // interrupt that vanishes mid-drain abandons the trap rather than taking it.
    always_comb begin
        w_next_state  = r_state;
        w_load_ecall  = 1'b0;
        w_load_timer  = 1'b0;
        O_csr_intr_wr = 1'b0;
        O_csr_intr_rd = 1'b0;
        O_csr_mret_wr = 1'b0;
        O_csr_mret_rd = 1'b0;
        O_intr_pc     = '0;
        O_intr_no     = '0;
        O_stall_if    = 1'b0;
        O_redirect    = 1'b0;
        O_redirect_pc = '0;
        case (r_state)
            ST_IDLE: begin
                if (I_wb_valid && I_wb_mret) begin
                    w_next_state = ST_MRET;
                end else if (I_wb_valid && I_wb_ecall) begin
                    w_next_state = ST_TRAP;
                    w_load_ecall = 1'b1;
                end else if (w_irq_take) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                O_stall_if = 1'b1;
                if (!w_irq_take) begin
                    w_next_state = ST_IDLE;
                end else if (I_pipe_empty) begin
                    w_next_state = ST_TRAP;
                    w_load_timer = 1'b1;
                end
            end
            ST_TRAP: begin
                O_stall_if    = 1'b1;
                O_csr_intr_wr = 1'b1;
                O_csr_intr_rd = 1'b1;
                O_intr_pc     = r_epc;
                O_intr_no     = r_cause;
                O_redirect    = 1'b1;
                O_redirect_pc = I_csr_rd_data[31:0];
                w_next_state  = ST_IDLE;
            end
            ST_MRET: begin
                O_stall_if    = 1'b1;
                O_csr_mret_wr = 1'b1;
                O_csr_mret_rd = 1'b1;
                O_redirect    = 1'b1;
                O_redirect_pc = I_csr_rd_data[31:0];
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// tb_ysyx_22040750_trap_ctrl: directed and randomized checks of the trap sequencer
// against a behavioural model; covers both YSYX_22040750_CLINT_EN builds.
module tb_ysyx_22040750_trap_ctrl;

   localparam int unsigned TB_TICK_DIV = 1;
   localparam logic [31:0] TB_BASE     = 32'h0200_0000;
   localparam logic [31:0] ADDR_CMP    = TB_BASE + 32'h0000_4000;
   localparam logic [31:0] ADDR_MTIME  = TB_BASE + 32'h0000_BFF8;
   localparam logic [63:0] ALL_ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] EXP_ECALL   = 64'd11;
   localparam logic [63:0] EXP_TIMER   = 64'h8000_0000_0000_0007;
`ifdef YSYX_22040750_CLINT_EN
   localparam bit CLINT_ON = 1'b1;
`else
   localparam bit CLINT_ON = 1'b0;
`endif

   typedef struct {
      logic        wbValid;
      logic        wbEcall;
      logic        wbMret;
      logic [31:0] wbPc;
      logic [31:0] nextPc;
      logic        pipeEmpty;
      logic        mie;
      logic [63:0] csrRdData;
      logic        timerIrq;
      logic        mmioWen;
      logic        mmioRen;
      logic [31:0] mmioAddr;
      logic [63:0] mmioWdata;
      logic [7:0]  mmioWmask;
   } stim_t;

   logic        sysClk = 1'b0;
   logic        rstN = 1'b0;
   logic        wbValid, wbEcall, wbMret, pipeEmpty, mie, timerIrq, mmioWen, mmioRen;
   logic [31:0] wbPc, nextPc, mmioAddr;
   logic [63:0] csrRdData, mmioWdata;
   logic [7:0]  mmioWmask;
   logic        intrWr, intrRd, mretWr, mretRd, stallIf, redirect;
   logic [31:0] intrPc, redirectPc;
   logic [63:0] intrNo, mmioRdata;

   int compareCount = 0;
   int mismatchCount = 0;

   // Behavioural model: what the sequencer owes the CSR file this cycle.
   int          eventKind;
   bit          draining;
   logic [31:0] epcM;
   logic [63:0] causeM;
   logic [63:0] mtimeM;
   logic [63:0] cmpM;
   int unsigned preM;

   always #5 sysClk = ~sysClk;

   ysyx_22040750_trap_ctrl #(.TICK_DIV(TB_TICK_DIV), .CLINT_BASE(TB_BASE)) dut (
      .I_sys_clk(sysClk), .I_rst_n(rstN),
      .I_wb_valid(wbValid), .I_wb_ecall(wbEcall), .I_wb_mret(wbMret), .I_wb_pc(wbPc),
      .I_next_pc(nextPc), .I_pipe_empty(pipeEmpty), .I_mstatus_mie(mie),
      .I_csr_rd_data(csrRdData),
      .O_csr_intr_wr(intrWr), .O_csr_intr_rd(intrRd), .O_csr_mret_wr(mretWr), .O_csr_mret_rd(mretRd),
      .O_intr_pc(intrPc), .O_intr_no(intrNo), .O_stall_if(stallIf),
      .O_redirect(redirect), .O_redirect_pc(redirectPc),
      .I_mmio_wen(mmioWen), .I_mmio_ren(mmioRen), .I_mmio_addr(mmioAddr),
      .I_mmio_wdata(mmioWdata), .I_mmio_wmask(mmioWmask),
`ifndef YSYX_22040750_CLINT_EN
      .I_timer_irq(timerIrq),
`endif
      .O_mmio_rdata(mmioRdata)
   );

   // Single point where every comparison is counted and reported.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s.wbValid = 1'b0; s.wbEcall = 1'b0; s.wbMret = 1'b0;
      s.wbPc = 32'h0; s.nextPc = 32'h0; s.pipeEmpty = 1'b0; s.mie = 1'b0;
      s.csrRdData = 64'h0; s.timerIrq = 1'b0;
      s.mmioWen = 1'b0; s.mmioRen = 1'b0; s.mmioAddr = 32'h0;
      s.mmioWdata = 64'h0; s.mmioWmask = 8'h0;
      return s;
   endfunction

   // Byte-lane merge expressed as a widened mask.
   function automatic logic [63:0] mergeBytes(input logic [63:0] oldVal, input logic [63:0] data, input logic [7:0] mask);
      logic [63:0] wide;
      wide = 64'h0;
      for (int i = 0; i < 8; i++) if (mask[i]) wide = wide | (64'hFF << (8 * i));
      return (oldVal & ~wide) | (data & wide);
   endfunction

   function automatic bit modelIrq(input stim_t s);
      if (CLINT_ON) return (mtimeM >= cmpM);
      return s.timerIrq;
   endfunction

   task automatic resetModel();
      eventKind = 0; draining = 1'b0; epcM = 32'h0; causeM = 64'h0;
      mtimeM = 64'h0; cmpM = ALL_ONES; preM = 0;
   endtask

   task automatic driveInputs(input stim_t s);
      wbValid = s.wbValid; wbEcall = s.wbEcall; wbMret = s.wbMret; wbPc = s.wbPc;
      nextPc = s.nextPc; pipeEmpty = s.pipeEmpty; mie = s.mie; csrRdData = s.csrRdData;
      timerIrq = s.timerIrq; mmioWen = s.mmioWen; mmioRen = s.mmioRen; mmioAddr = s.mmioAddr;
      mmioWdata = s.mmioWdata; mmioWmask = s.mmioWmask;
   endtask

   task automatic checkAll(input stim_t s);
      bit          isTrap, isMret, isRedir;
      logic [63:0] expRd;
      isTrap  = (eventKind == 1);
      isMret  = (eventKind == 2);
      isRedir = isTrap || isMret;
      expRd   = 64'h0;
      if (CLINT_ON && s.mmioRen && s.mmioAddr == ADDR_CMP)        expRd = cmpM;
      else if (CLINT_ON && s.mmioRen && s.mmioAddr == ADDR_MTIME) expRd = mtimeM;
      checkOutput("intr_wr", intrWr, isTrap);
      checkOutput("intr_rd", intrRd, isTrap);
      checkOutput("mret_wr", mretWr, isMret);
      checkOutput("mret_rd", mretRd, isMret);
      checkOutput("intr_pc", intrPc, isTrap ? epcM : 32'h0);
      checkOutput("intr_no", intrNo, isTrap ? causeM : 64'h0);
      checkOutput("stall_if", stallIf, draining || isRedir);
      checkOutput("redirect", redirect, isRedir);
      checkOutput("redirect_pc", redirectPc, isRedir ? s.csrRdData[31:0] : 32'h0);
      checkOutput("mmio_rdata", mmioRdata, expRd);
   endtask

   task automatic modelAdvance(input stim_t s);
      bit irqTake, tick;
      irqTake = modelIrq(s) && s.mie;
      if (eventKind != 0) begin
         eventKind = 0;
      end else if (draining) begin
         if (!irqTake) draining = 1'b0;
         else if (s.pipeEmpty) begin
            draining = 1'b0; eventKind = 1; epcM = s.nextPc; causeM = EXP_TIMER;
         end
      end else if (s.wbValid && s.wbMret) begin
         eventKind = 2;
      end else if (s.wbValid && s.wbEcall) begin
         eventKind = 1; epcM = s.wbPc; causeM = EXP_ECALL;
      end else if (irqTake) begin
         draining = 1'b1;
      end
      if (CLINT_ON) begin
         tick = (preM + 1 == TB_TICK_DIV);
         preM = tick ? 0 : preM + 1;
         if (s.mmioWen && s.mmioAddr == ADDR_CMP) cmpM = mergeBytes(cmpM, s.mmioWdata, s.mmioWmask);
         if (s.mmioWen && s.mmioAddr == ADDR_MTIME) mtimeM = mergeBytes(mtimeM, s.mmioWdata, s.mmioWmask);
         else if (tick) mtimeM = mtimeM + 64'd1;
      end
   endtask

   // One clock: drive on the falling edge, check after settling, then step the model.
   task automatic applyStimulus(input stim_t s);
      @(negedge sysClk);
      driveInputs(s);
      #1;
      checkAll(s);
      modelAdvance(s);
   endtask

   // Assert reset mid-cycle, check everything is idle, release away from the clock edge.
   task automatic pulseReset(input stim_t s);
      @(negedge sysClk);
      driveInputs(s);
      rstN = 1'b0;
      #1;
      resetModel();
      checkAll(s);
      @(posedge sysClk);
      #2;
      rstN = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stim_t s;
      int    waitCycles;
      resetModel();
      driveInputs(idleStim());

      // Reset state, including the mtimecmp reset value through MMIO.
      s = idleStim(); s.mmioRen = 1'b1; s.mmioAddr = ADDR_CMP; s.csrRdData = 64'h1234_5678_9ABC_DEF0;
      pulseReset(s);
      checkOutput("rst_cmp_read", mmioRdata, CLINT_ON ? ALL_ONES : 64'h0);
      checkOutput("rst_stall", stallIf, 1'b0);

      // ecall at WB, trap strobes one cycle later.
      s = idleStim(); s.wbValid = 1'b1; s.wbEcall = 1'b1; s.wbPc = 32'h8000_0010;
      applyStimulus(s);
      s = idleStim(); s.csrRdData = 64'hDEAD_BEEF_8000_0100;
      applyStimulus(s);
      checkOutput("ecall_intr_wr", intrWr, 1'b1);
      checkOutput("ecall_intr_no", intrNo, EXP_ECALL);
      checkOutput("ecall_intr_pc", intrPc, 32'h8000_0010);
      checkOutput("ecall_redirect_pc", redirectPc, 32'h8000_0100);

      // mret (with ecall also set) must win and produce mret strobes only.
      s = idleStim(); s.wbValid = 1'b1; s.wbMret = 1'b1; s.wbEcall = 1'b1; s.wbPc = 32'h8000_0200;
      applyStimulus(s);
      s = idleStim(); s.csrRdData = 64'h0000_0000_8000_0014;
      applyStimulus(s);
      checkOutput("mret_wr_one", mretWr, 1'b1);
      checkOutput("mret_rd_one", mretRd, 1'b1);
      checkOutput("mret_redirect_pc", redirectPc, 32'h8000_0014);
      checkOutput("mret_intr_wr", intrWr, 1'b0);

      // Timer interrupt: mtimecmp = 10, wait for detection, drain 3 cycles, then trap.
      s = idleStim(); s.mmioWen = 1'b1; s.mmioAddr = ADDR_CMP; s.mmioWdata = 64'd10; s.mmioWmask = 8'hFF;
      applyStimulus(s);
      s = idleStim(); s.mie = 1'b1; s.timerIrq = 1'b1; s.nextPc = 32'h8000_0040;
      waitCycles = 0;
      while (!draining && waitCycles < 40) begin
         applyStimulus(s);
         waitCycles++;
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(s);
         checkOutput("drain_stall", stallIf, 1'b1);
         checkOutput("drain_no_strobe", intrWr, 1'b0);
      end
      s.pipeEmpty = 1'b1;
      applyStimulus(s);
      s.pipeEmpty = 1'b0; s.mie = 1'b0; s.csrRdData = 64'h8000_0100;
      applyStimulus(s);
      checkOutput("timer_intr_wr", intrWr, 1'b1);
      checkOutput("timer_intr_no", intrNo, EXP_TIMER);
      checkOutput("timer_intr_pc", intrPc, 32'h8000_0040);

      // Interrupt still pending but MIE clear: nothing happens.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(s);
         checkOutput("mie0_stall", stallIf, 1'b0);
         checkOutput("mie0_intr_wr", intrWr, 1'b0);
      end

      // ecall and pending interrupt together: ecall first, no timer trap afterwards.
      s = idleStim(); s.timerIrq = 1'b1; s.mie = 1'b1; s.wbValid = 1'b1; s.wbEcall = 1'b1; s.wbPc = 32'h8000_0020;
      applyStimulus(s);
      s = idleStim(); s.timerIrq = 1'b1; s.csrRdData = 64'h8000_0100;
      applyStimulus(s);
      checkOutput("both_intr_no", intrNo, EXP_ECALL);
      checkOutput("both_intr_pc", intrPc, 32'h8000_0020);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(s);
         checkOutput("both_after_stall", stallIf, 1'b0);
      end

      // mtime wrap from all ones and a byte-masked mtimecmp write.
      s = idleStim(); s.mmioWen = 1'b1; s.mmioAddr = ADDR_MTIME; s.mmioWdata = ALL_ONES; s.mmioWmask = 8'hFF;
      applyStimulus(s);
      s = idleStim(); s.mmioRen = 1'b1; s.mmioAddr = ADDR_MTIME;
      applyStimulus(s);
      checkOutput("wrap_all_ones", mmioRdata, CLINT_ON ? ALL_ONES : 64'h0);
      applyStimulus(s);
      checkOutput("wrap_zero", mmioRdata, 64'h0);
      s = idleStim(); s.mmioWen = 1'b1; s.mmioAddr = ADDR_CMP; s.mmioWdata = 64'h1111_2222_3333_4444; s.mmioWmask = 8'h0F;
      applyStimulus(s);
      s = idleStim(); s.mmioRen = 1'b1; s.mmioAddr = ADDR_CMP;
      applyStimulus(s);
      checkOutput("masked_cmp", mmioRdata, CLINT_ON ? 64'h0000_0000_3333_4444 : 64'h0);

      // Reset pulse while draining: straight back to idle, no strobe afterwards.
      s = idleStim(); s.timerIrq = 1'b1; s.mmioWen = 1'b1; s.mmioAddr = ADDR_CMP; s.mmioWmask = 8'hFF;
      applyStimulus(s);
      s = idleStim(); s.timerIrq = 1'b1; s.mie = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("pre_reset_drain", stallIf, 1'b1);
      s = idleStim(); s.mie = 1'b1; s.pipeEmpty = 1'b1;
      pulseReset(s);
      checkOutput("reset_drain_stall", stallIf, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(s);
         checkOutput("post_reset_intr_wr", intrWr, 1'b0);
      end

      // Randomized traffic against the model.
      s = idleStim();
      for (int c = 0; c < 3000; c++) begin
         s.wbValid   = 1'($urandom_range(0, 1));
         s.wbEcall   = ($urandom_range(0, 3) == 0);
         s.wbMret    = ($urandom_range(0, 5) == 0);
         s.wbPc      = $urandom;
         s.nextPc    = $urandom;
         s.pipeEmpty = ($urandom_range(0, 2) == 0);
         s.mie       = ($urandom_range(0, 3) != 0);
         s.csrRdData = {$urandom, $urandom};
         if ($urandom_range(0, 15) == 0) s.timerIrq = ~s.timerIrq;
         s.mmioRen   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       s.mmioAddr = ADDR_CMP;
            1:       s.mmioAddr = ADDR_MTIME;
            2:       s.mmioAddr = TB_BASE;
            default: s.mmioAddr = $urandom;
         endcase
         s.mmioWen   = ($urandom_range(0, 19) == 0);
         s.mmioWmask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(1, 255));
         if (s.mmioAddr == ADDR_CMP) s.mmioWdata = mtimeM + 64'($urandom_range(0, 30));
         else                        s.mmioWdata = 64'($urandom_range(0, 1000));
         applyStimulus(s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
